// File: rtl/obj_scan_pkg.sv
// Shared types for the OBJ scanline evaluator: FSM states, list entry layout
// and the shape/size to vertical-extent lookup.
package obj_scan_pkg;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_EVAL, S_DONE} state_t;

    typedef struct packed {
        logic [6:0] index;
        logic [6:0] yoff;
        logic [8:0] x;
    } entry_t;

    // Height in lines; shape 2'b11 is invalid and is filtered out before use.
    function automatic logic [7:0] obj_vsize(input logic [1:0] shape,
                                             input logic [1:0] size,
                                             input logic       dbl);
        logic [7:0] v;
        case (shape)
            2'b00: v = 8'd8 << size;
            2'b01: case (size)
                       2'd0, 2'd1: v = 8'd8;
                       2'd2:       v = 8'd16;
                       default:    v = 8'd32;
                   endcase
            2'b10: case (size)
                       2'd0:       v = 8'd16;
                       2'd1, 2'd2: v = 8'd32;
                       default:    v = 8'd64;
                   endcase
            default: v = 8'd0;
        endcase
        return dbl ? {v[6:0], 1'b0} : v;
    endfunction

endpackage

// File: rtl/obj_counter.sv
// Object index counter with synchronous clear and increment.
module obj_counter #(
    parameter int W = 7
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   count <= '0;
        else if (clear) count <= '0;
        else if (inc)   count <= count + 1'b1;
    end

endmodule

// File: rtl/obj_list_fifo.sv
// Visible-object list: power-of-two FIFO with flush; head reads as zero when empty.
module obj_list_fifo
    import obj_scan_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 din,
    output entry_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/obj_scan_controller.sv
// Per-scanline OAM walker: fetches each object's attributes, tests vertical
// overlap with the requested row and queues visible objects in index order.
module obj_scan_controller
    import obj_scan_pkg::*;
#(
    parameter int NUM_OBJS   = 128,
    parameter int LIST_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        line_start,
    input  logic [7:0]  row,
    input  logic        obj_enable,
    output logic        oam_req,
    output logic [6:0]  oam_addr,
    input  logic        oam_ready,
    input  logic [15:0] oam_attr0,
    input  logic [15:0] oam_attr1,
    output logic        ent_valid,
    input  logic        ent_ready,
    output logic [6:0]  ent_index,
    output logic [6:0]  ent_yoff,
    output logic [8:0]  ent_x,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam int CW = $clog2(LIST_DEPTH) + 1;

    state_t        state;
    logic [7:0]    row_q, y_q, d;
    logic [1:0]    shape_q, mode_q, size_q;
    logic [8:0]    x_q;
    logic [7:0]    vsize;
    logic [6:0]    index;
    logic [CW-1:0] list_count;
    logic          list_full, list_empty;
    logic          skip, hit, last, at_cap, push, idx_inc;
    entry_t        head;

    assign d       = row_q - y_q;
    assign vsize   = obj_vsize(shape_q, size_q, mode_q == 2'b11);
    assign skip    = (mode_q == 2'b10) || (shape_q == 2'b11);
    assign hit     = (state == S_EVAL) && !skip && (d < vsize);
    assign last    = (index == 7'(NUM_OBJS - 1));
    assign at_cap  = (list_count == CW'(LIST_DEPTH));
    assign push    = hit && !list_full && !line_start;
    assign idx_inc = (state == S_EVAL) && !line_start && !last && !(hit && at_cap);

    assign oam_addr  = index;
    assign ent_valid = !list_empty;
    assign ent_index = head.index;
    assign ent_yoff  = head.yoff;
    assign ent_x     = head.x;

    obj_counter #(.W(7)) u_idx (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (line_start),
        .inc     (idx_inc),
        .count   (index)
    );

    obj_list_fifo #(.DEPTH(LIST_DEPTH)) u_list (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (line_start),
        .push    (push),
        .pop     (ent_valid && ent_ready),
        .din     ('{index: index, yoff: d[6:0], x: x_q}),
        .dout    (head),
        .full    (list_full),
        .empty   (list_empty),
        .count   (list_count)
    );

    // line_start preempts every state, including an in-flight OAM read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            oam_req  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            row_q    <= '0;
            y_q      <= '0;
            shape_q  <= '0;
            mode_q   <= '0;
            size_q   <= '0;
            x_q      <= '0;
        end else begin
            done <= 1'b0;
            if (line_start) begin
                overflow <= 1'b0;
                row_q    <= row;
                state    <= obj_enable ? S_REQ : S_DONE;
                oam_req  <= obj_enable;
                busy     <= obj_enable;
                done     <= !obj_enable;
            end else begin
                case (state)
                    S_REQ: if (oam_ready) begin
                        y_q     <= oam_attr0[7:0];
                        mode_q  <= oam_attr0[9:8];
                        shape_q <= oam_attr0[15:14];
                        size_q  <= oam_attr1[15:14];
                        x_q     <= oam_attr1[8:0];
                        oam_req <= 1'b0;
                        state   <= S_EVAL;
                    end
                    S_EVAL: begin
                        if ((hit && at_cap) || last) begin
                            overflow <= hit && at_cap;
                            state    <= S_DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            state   <= S_REQ;
                            oam_req <= 1'b1;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/obj_scan_controller.md
OBJ_SCAN_CONTROLLER -- requirements
Module: obj_scan_controller

Interface
REQ-001 SHALL have parameter NUM_OBJS, default 128, number of OAM entries scanned per line.
REQ-002 SHALL have parameter LIST_DEPTH, default 16, capacity of the visible-object list (power of two).
REQ-003 SHALL have port clock  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port line_start  in  1  one-cycle pulse: begin scan for row.
REQ-006 SHALL have port row  in  8  scanline to evaluate, sampled on line_start.
REQ-007 SHALL have port obj_enable  in  1  OBJ layer enable, sampled on line_start.
REQ-008 SHALL have ports oam_req  out  1 and oam_addr  out  7: OAM read request and object index.
REQ-009 SHALL have ports oam_ready  in  1, oam_attr0  in  16, oam_attr1  in  16: attributes valid while oam_ready is high.
REQ-010 SHALL have ports ent_valid  out  1 and ent_ready  in  1: list output handshake.
REQ-011 SHALL have ports ent_index  out  7, ent_yoff  out  7, ent_x  out  9: object index, row offset within object, attr1[8:0].
REQ-012 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), overflow  out  1 (sticky per line).

Function
REQ-013 SHALL implement FSM IDLE -> REQ -> EVAL -> (REQ | DONE) -> IDLE.
REQ-014 line_start SHALL, from any state, clear the list, overflow and index, latch row and obj_enable, and enter REQ (or DONE when obj_enable=0).
REQ-015 SHALL drive oam_req=1 with oam_addr=index in REQ only, holding both until oam_ready=1, then capture attributes and enter EVAL.
REQ-016 oam_req SHALL assert the cycle after line_start; minimum throughput is 2 cycles per object.
REQ-017 EVAL SHALL skip the object when attr0[9:8]=2'b10 (disabled) or attr0[15:14]=2'b11 (invalid shape).
REQ-018 vsize SHALL come from shape attr0[15:14] and size attr1[15:14]: square 8/16/32/64, horizontal 8/8/16/32, vertical 16/32/32/64; doubled when attr0[9:8]=2'b11.
REQ-019 The object SHALL be visible when d=(row-attr0[7:0]) mod 256 satisfies d<vsize (8-bit wrap, so Y near 255 reaches rows 0+); ent_yoff=d[6:0].
REQ-020 A visible object SHALL be pushed in EVAL; an entry SHALL appear on ent_valid no earlier than the cycle after the push.
REQ-021 Visible object with list full SHALL set overflow, push nothing, and enter DONE immediately.
REQ-022 After EVAL of index NUM_OBJS-1, SHALL enter DONE; index SHALL not wrap.
REQ-023 DONE SHALL pulse done for one cycle, then return to IDLE; busy=1 in REQ and EVAL only.
REQ-024 List SHALL be FIFO in ascending index order; push and pop in the same cycle SHALL both occur and leave count unchanged.
REQ-025 Pop occurs when ent_valid & ent_ready; ent_* SHALL stay stable while ent_valid=1 and ent_ready=0.
REQ-026 Entries remain poppable after done until the next line_start clears them.

Reset
REQ-027 reset_n=0 SHALL asynchronously force IDLE with oam_req, oam_addr, ent_valid, ent_index, ent_yoff, ent_x, busy, done and overflow all 0, and the list empty.
REQ-028 Reset mid-scan SHALL discard all state; the first activity after reset SHALL be the next line_start.

Structure
REQ-029 Package obj_scan_pkg SHALL hold the state enum, the list entry struct {index, yoff, x}, and the shape/size-to-vsize function.
REQ-030 The list SHALL be sub-module obj_list_fifo (LIST_DEPTH entries, push/pop/full/empty/count); the index counter SHALL reuse obj_counter.

Verification
REQ-031 OAM all disabled (attr0=16'h0200), row=10, oam_ready always 1 -> done 256 cycles after oam_req first asserts; ent_valid never 1; overflow=0.
REQ-032 Obj 5: Y=250, square size 1 (16 lines), X=100; row=3 -> one entry {5, yoff=9, x=100}.
REQ-033 Obj 7: affine double-size, square size 3, Y=0; row=127 -> entry yoff=127; row=128 -> no entry.
REQ-034 20 visible objects, LIST_DEPTH=16, ent_ready=0 -> 16 entries (indices 0..15), overflow=1, done right after the 17th visible EVAL.
REQ-035 oam_ready delayed 3 cycles per read -> oam_req/oam_addr held stable; results identical to zero-wait run.
REQ-036 line_start mid-scan at index 40 with ent_ready toggling -> list cleared, overflow=0, scan restarts at index 0 the next cycle; reset_n low mid-scan -> all outputs 0 at once.
